ts_pkt_checker: RTL and testbench
=================================

// Module: ts_pkt_checker
// PURPOSE
//   Consumes the 188-byte TS stream produced by the scrambler-side TS source.
//   Checks each packet (sync byte, PID, continuity counter, length, payload ramp)
//   and reports per-packet error flags and saturating packet/error counters.
//   It is the downstream monitor stage for the scrambler path and its bench.
// PARAMETERS
//   EXP_PID      13'h0014  expected PID ({byte2[4:0],byte3})
//   PKT_LEN      188       bytes per packet, counted sync to eop inclusive
//   CHK_PAYLOAD  1         1 = check payload ramp when AFC==2'b01
//   CNT_W        16        width of pkt_cnt / err_cnt
// PORTS
//   clk          in   1      clock
//   rst          in   1      asynchronous, active-high reset
//   ts_sync      in   1      first byte of packet; qualified by ts_valid
//   ts_valid     in   1      byte strobe
//   ts_eop       in   1      last byte of packet; qualified by ts_valid
//   ts_data      in   8      TS byte
//   clr_cnt      in   1      synchronous clear of counters and CC history
//   pkt_done     out  1      1-cycle pulse; err_* and pkt_ok valid with it
//   pkt_ok       out  1      closed packet had no error
//   err_sync     out  1      byte 1 != 8'h47
//   err_pid      out  1      PID != EXP_PID
//   err_cc       out  1      continuity counter discontinuity
//   err_len      out  1      packet length != PKT_LEN
//   err_payload  out  1      payload byte mismatch
//   pkt_cnt      out  CNT_W  packets closed, saturating
//   err_cnt      out  CNT_W  packets closed with !pkt_ok, saturating
// BEHAVIOUR
//   - Reset: all outputs 0, FSM IDLE, idx=0, CC history invalid.
//   - A byte is accepted only when ts_valid=1. Gaps (ts_valid=0) are legal anywhere; idx holds.
//   - FSM IDLE: an accepted byte with ts_sync=1 -> RECV, idx=1. Other bytes are ignored.
//   - FSM RECV: idx increments per accepted byte. Packet closes on the first of:
//     a) ts_eop at idx==PKT_LEN: normal close.
//     b) ts_eop at idx<PKT_LEN: err_len.
//     c) byte PKT_LEN without ts_eop: err_len.
//     d) ts_sync at idx>1: err_len on the current packet. That byte starts a new packet (idx=1, stays RECV).
//   - Close sets pkt_done=1 on the next cycle. err_*/pkt_ok register at close and hold until the next close.
//     After a close with ts_sync=0, FSM -> IDLE.
//   - Byte 1 must be 8'h47. Bytes 2,3 give PID; TEI/PUSI/priority bits are ignored.
//   - Byte 4: AFC=data[5:4], CC=data[3:0].
//     If history is invalid, store CC, set history valid, no err_cc.
//     Otherwise expected = prev+1 mod 16 if AFC[0]=1, else expected = prev.
//     Mismatch -> err_cc. Always store received CC. 4'hF->4'h0 is legal.
//   - Payload bytes idx 5..PKT_LEN must equal (idx-4)[7:0]: byte5=8'h01, byte188=8'hB8.
//     Checked only if CHK_PAYLOAD=1 and AFC==2'b01. Any mismatch -> err_payload.
//   - A packet truncated before byte 4 gets err_len only, and CC history is unchanged.
//   - Counters increment on pkt_done and saturate at all-ones.
//   - clr_cnt: clears pkt_cnt/err_cnt and invalidates CC history. It wins over a same-cycle increment.
//     It does not abort a packet in progress.
//   - Async rst mid-packet: packet is discarded with no pkt_done. Checking restarts at the next sync.
// STRUCTURE
//   - ts_defs.vh (shared): TS_SYNC_BYTE 8'h47, TS_PKT_LEN 188, AFC codes, FSM encodings IDLE/RECV.
//   - Sub-module ts_sat_cnt (CNT_W, inc, clr, q), instantiated twice for pkt_cnt/err_cnt.
//   - Rest is flat: FSM, idx counter, header capture regs, sticky error accumulators.
// TESTING
//   1. Source defaults, PKT_INTERVAL=10, 20 packets -> 20 pkt_done, all pkt_ok=1, pkt_cnt=20, err_cnt=0.
//   2. Packet 3 byte1 forced 8'h46 -> only err_sync on packet 3; err_cnt=1. Packet 4 is ok.
//   3. Suppress one packet, so CC jumps 5->7 -> err_cc on the CC=7 packet only.
//      CC wrap F->0 over 40 packets -> no err_cc.
//   4. ts_eop at byte 100 -> err_len, pkt_done next cycle. Next full packet is ok.
//      Sync at byte 50 -> err_len, and the new packet is checked ok.
//   5. AFC=2'b10 with repeated CC, payload garbage -> pkt_ok=1.
//      AFC=2'b01 with byte 100 flipped -> err_payload.
//   6. rst at byte 90, then clean stream -> no spurious pkt_done, first packet ok.
//      clr_cnt at pkt_done -> counters read 0.

Source files
------------

// File: rtl/ts_pkt_checker_pkg.sv
// Shared constants, state encoding and header helpers for the TS packet checker.
package ts_pkt_checker_pkg;

    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
    localparam int         TS_PKT_LEN   = 188;
    localparam logic [1:0] AFC_PAYLOAD  = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Sticky per-packet errors gathered while bytes arrive; length is decided at close.
    typedef struct packed {
        logic sync;
        logic pid;
        logic cc;
        logic payload;
    } err_acc_t;

    // The continuity counter only advances when the packet carries payload (AFC[0]).
    function automatic logic [3:0] next_cc(input logic [3:0] prev, input logic afc0);
        return afc0 ? prev + 4'd1 : prev;
    endfunction

endpackage

// File: rtl/ts_sat_cnt.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module ts_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/ts_pkt_checker.sv
// Downstream monitor for the 188-byte TS stream: per-packet header/length/payload
// checks with registered error flags and saturating packet/error counters.
module ts_pkt_checker
    import ts_pkt_checker_pkg::*;
#(
    parameter logic [12:0] EXP_PID     = 13'h0014,
    parameter int          PKT_LEN     = TS_PKT_LEN,
    parameter bit          CHK_PAYLOAD = 1'b1,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ts_sync,
    input  logic             ts_valid,
    input  logic             ts_eop,
    input  logic [7:0]       ts_data,
    input  logic             clr_cnt,
    output logic             pkt_done,
    output logic             pkt_ok,
    output logic             err_sync,
    output logic             err_pid,
    output logic             err_cc,
    output logic             err_len,
    output logic             err_payload,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int             IDX_W    = $clog2(PKT_LEN + 1);
    localparam logic [IDX_W-1:0] IDX_1  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_2  = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_3  = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_4  = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN);

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [4:0]       pid_hi_reg, pid_hi_next;
    logic [1:0]       afc_reg, afc_next;
    err_acc_t         acc_reg;
    logic             hist_valid_reg, hist_valid_next;
    logic [3:0]       prev_cc_reg, prev_cc_next;
    logic             pkt_done_reg, pkt_ok_reg;
    logic             err_sync_reg, err_pid_reg, err_cc_reg, err_len_reg, err_payload_reg;

    logic             accept, restart, close, close_len_err, trunc;
    logic [IDX_W-1:0] n;
    logic [7:0]       exp_byte;
    logic [3:0]       cc_exp;
    err_acc_t         cur, res;

    always_comb begin
        accept          = ts_valid && ((state_reg == RECV) || ts_sync);
        restart         = accept && ts_sync && (state_reg == RECV);
        n               = ts_sync ? IDX_1 : idx_reg + IDX_1;
        cur             = ts_sync ? err_acc_t'('0) : acc_reg;
        pid_hi_next     = pid_hi_reg;
        afc_next        = afc_reg;
        hist_valid_next = hist_valid_reg;
        prev_cc_next    = prev_cc_reg;
        exp_byte        = 8'(n - IDX_4);
        cc_exp          = next_cc(prev_cc_reg, ts_data[4]);

        // Evaluate the accepted byte against the packet it belongs to (a sync byte starts fresh).
        if (accept) begin
            if (n == IDX_1) begin
                cur.sync = (ts_data != TS_SYNC_BYTE);
            end else if (n == IDX_2) begin
                pid_hi_next = ts_data[4:0];
            end else if (n == IDX_3) begin
                cur.pid = ({pid_hi_reg, ts_data} != EXP_PID);
            end else if (n == IDX_4) begin
                afc_next        = ts_data[5:4];
                cur.cc          = hist_valid_reg && (ts_data[3:0] != cc_exp);
                hist_valid_next = 1'b1;
                prev_cc_next    = ts_data[3:0];
            end else if (CHK_PAYLOAD && (afc_reg == AFC_PAYLOAD) && (ts_data != exp_byte)) begin
                cur.payload = 1'b1;
            end
        end
        if (clr_cnt) begin
            hist_valid_next = 1'b0;
        end

        // A sync inside a packet closes the old one with what it had so far.
        close = restart || (accept && (ts_eop || (n == IDX_LAST)));
        if (restart) begin
            res           = acc_reg;
            trunc         = (idx_reg < IDX_4);
            close_len_err = 1'b1;
        end else begin
            res           = cur;
            trunc         = (n < IDX_4);
            close_len_err = !(ts_eop && (n == IDX_LAST));
        end
        if (trunc) begin
            res = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            pid_hi_reg      <= '0;
            afc_reg         <= '0;
            acc_reg         <= '0;
            hist_valid_reg  <= 1'b0;
            prev_cc_reg     <= '0;
            pkt_done_reg    <= 1'b0;
            pkt_ok_reg      <= 1'b0;
            err_sync_reg    <= 1'b0;
            err_pid_reg     <= 1'b0;
            err_cc_reg      <= 1'b0;
            err_len_reg     <= 1'b0;
            err_payload_reg <= 1'b0;
        end else begin
            pkt_done_reg   <= close;
            pid_hi_reg     <= pid_hi_next;
            afc_reg        <= afc_next;
            hist_valid_reg <= hist_valid_next;
            prev_cc_reg    <= prev_cc_next;
            if (close) begin
                err_sync_reg    <= res.sync;
                err_pid_reg     <= res.pid;
                err_cc_reg      <= res.cc;
                err_payload_reg <= res.payload;
                err_len_reg     <= close_len_err;
                pkt_ok_reg      <= !(|res) && !close_len_err;
            end
            if (accept) begin
                if (close && !restart) begin
                    state_reg <= IDLE;
                    idx_reg   <= '0;
                    acc_reg   <= '0;
                end else begin
                    state_reg <= RECV;
                    idx_reg   <= n;
                    acc_reg   <= cur;
                end
            end
        end
    end

    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_q [2];

    assign cnt_inc = {pkt_done_reg && !pkt_ok_reg, pkt_done_reg};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            ts_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (cnt_inc[gi]),
                .clr (clr_cnt),
                .q   (cnt_q[gi])
            );
        end
    endgenerate

    assign pkt_cnt     = cnt_q[0];
    assign err_cnt     = cnt_q[1];
    assign pkt_done    = pkt_done_reg;
    assign pkt_ok      = pkt_ok_reg;
    assign err_sync    = err_sync_reg;
    assign err_pid     = err_pid_reg;
    assign err_cc      = err_cc_reg;
    assign err_len     = err_len_reg;
    assign err_payload = err_payload_reg;

endmodule

// File: tb/tb_ts_pkt_checker.sv
// Directed and randomized packet stream against a packet-level reference model.
module tb_ts_pkt_checker;

    logic        clk = 1'b0;
    logic        rst, ts_sync, ts_valid, ts_eop, clr_cnt;
    logic [7:0]  ts_data;
    logic        pkt_done, pkt_ok, err_sync, err_pid, err_cc, err_len, err_payload;
    logic [15:0] pkt_cnt, err_cnt;

    always #5 clk = ~clk;

    ts_pkt_checker dut (
        .clk(clk), .rst(rst), .ts_sync(ts_sync), .ts_valid(ts_valid), .ts_eop(ts_eop),
        .ts_data(ts_data), .clr_cnt(clr_cnt), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
        .err_sync(err_sync), .err_pid(err_pid), .err_cc(err_cc), .err_len(err_len),
        .err_payload(err_payload), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  pkt [1:256];
    logic [5:0]  got_q [$];
    logic [5:0]  exp_q [$];
    bit          hv;
    logic [3:0]  pcc;
    logic [3:0]  src_cc;
    int          mcnt, mecnt;

    // {ok, sync, pid, cc, len, payload} of every closed packet
    always @(negedge clk)
        if (pkt_done) got_q.push_back({pkt_ok, err_sync, err_pid, err_cc, err_len, err_payload});

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [1:0] afc, input logic [3:0] cc);
        pkt[1] = 8'h47;
        pkt[2] = {3'($urandom_range(0, 7)), 5'h00};
        pkt[3] = 8'h14;
        pkt[4] = {2'($urandom_range(0, 3)), afc, cc};
        for (int i = 5; i <= 188; i++) pkt[i] = 8'(i - 4);
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit s, input bit e);
        if ($urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                ts_valid = 1'b0;
                ts_sync  = 1'($urandom);
                ts_eop   = 1'($urandom);
                ts_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        ts_valid = 1'b1;
        ts_sync  = s;
        ts_eop   = e;
        ts_data  = b;
    endtask

    task automatic send(input int len, input bit eop, input bit clr_at_done);
        for (int i = 1; i <= len; i++) drive_byte(pkt[i], i == 1, eop && (i == len));
        @(posedge clk);
        #1;
        ts_valid = 1'b0;
        ts_sync  = 1'b0;
        ts_eop   = 1'b0;
        if (eop || len == 188) begin
            chk($sformatf("done_latency len=%0d", len), pkt_done, 1);
            if (clr_at_done) begin
                clr_cnt = 1'b1;
                @(posedge clk);
                #1;
                clr_cnt = 1'b0;
            end
        end
    endtask

    // Expected verdict for a closed packet of len bytes, from the packet rules.
    task automatic model_pkt(input int len, input bit eop);
        bit s, p, c, l, y, ok;
        logic [1:0] afc;
        logic [3:0] cc, want;
        s = 0; p = 0; c = 0; y = 0;
        l = !(eop && len == 188);
        if (len >= 4) begin
            s   = (pkt[1] != 8'h47);
            p   = ({pkt[2][4:0], pkt[3]} != 13'h0014);
            afc = pkt[4][5:4];
            cc  = pkt[4][3:0];
            want = afc[0] ? pcc + 4'd1 : pcc;
            if (hv) c = (cc != want);
            hv  = 1;
            pcc = cc;
            if (afc == 2'b01)
                for (int i = 5; i <= len; i++) if (pkt[i] != 8'(i - 4)) y = 1;
        end
        ok = !(s | p | c | l | y);
        exp_q.push_back({ok, s, p, c, l, y});
        mcnt++;
        if (!ok) mecnt++;
    endtask

    task automatic std_pkt();
        build(2'b01, src_cc);
        src_cc++;
        send(188, 1, 0);
        model_pkt(188, 1);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk({tag, " result_count"}, got_q.size(), exp_q.size());
        for (int k = 0; exp_q.size() > 0 && got_q.size() > 0; k++)
            chk($sformatf("%s pkt%0d flags", tag, k), got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        chk({tag, " pkt_cnt"}, pkt_cnt, mcnt);
        chk({tag, " err_cnt"}, err_cnt, mecnt);
    endtask

    initial begin
        rst = 1'b1; ts_sync = 0; ts_valid = 0; ts_eop = 0; ts_data = 0; clr_cnt = 0;
        hv = 0; pcc = 0; src_cc = 0; mcnt = 0; mecnt = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset flags", {pkt_done, pkt_ok, err_sync, err_pid, err_cc, err_len, err_payload}, 0);
        chk("reset pkt_cnt", pkt_cnt, 0);
        chk("reset err_cnt", err_cnt, 0);

        // Clean stream
        repeat (20) std_pkt();
        drain("clean20");

        // Bad sync byte on packet 3
        for (int k = 1; k <= 5; k++) begin
            build(2'b01, src_cc);
            src_cc++;
            if (k == 3) pkt[1] = 8'h46;
            send(188, 1, 0);
            model_pkt(188, 1);
        end
        drain("badsync");

        // One packet suppressed, then a long run across CC wrap
        repeat (3) std_pkt();
        src_cc++;
        repeat (2) std_pkt();
        drain("ccskip");
        repeat (40) std_pkt();
        drain("ccwrap");

        // Length faults: early eop, truncation before byte 4, missing eop, sync at byte 50
        build(2'b01, src_cc); src_cc++;
        send(100, 1, 0); model_pkt(100, 1);
        std_pkt();
        build(2'b01, src_cc);
        send(3, 1, 0); model_pkt(3, 1);
        std_pkt();
        build(2'b01, src_cc); src_cc++;
        send(188, 0, 0); model_pkt(188, 0);
        build(2'b01, src_cc); src_cc++;
        send(49, 0, 0); model_pkt(49, 0);
        std_pkt();
        drain("length");

        // Adaptation-only packet with repeated CC and garbage, then a flipped payload byte
        build(2'b10, src_cc - 4'd1);
        for (int i = 5; i <= 188; i++) pkt[i] = 8'($urandom);
        send(188, 1, 0); model_pkt(188, 1);
        build(2'b01, src_cc); src_cc++;
        pkt[100] = pkt[100] ^ 8'hFF;
        send(188, 1, 0); model_pkt(188, 1);
        std_pkt();
        drain("payload");

        // Reset mid-packet
        build(2'b01, src_cc); src_cc++;
        send(89, 0, 0);
        #2;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hv = 0; mcnt = 0; mecnt = 0;
        @(negedge clk);
        chk("midrst spurious", got_q.size(), 0);
        chk("midrst flags", {pkt_done, pkt_ok, err_sync, err_pid, err_cc, err_len, err_payload}, 0);
        got_q.delete();
        repeat (3) std_pkt();
        drain("midrst");

        // Counter clear coinciding with pkt_done; also drops CC history
        build(2'b01, src_cc); src_cc++;
        send(188, 1, 1);
        model_pkt(188, 1);
        hv = 0; mcnt = 0; mecnt = 0;
        @(negedge clk);
        chk("clr pkt_cnt", pkt_cnt, 0);
        chk("clr err_cnt", err_cnt, 0);
        src_cc = src_cc + 4'd3;
        std_pkt();
        drain("clr");

        // Randomized faults
        for (int r = 0; r < 30; r++) begin
            int m;
            m = $urandom_range(0, 7);
            build(2'b01, src_cc);
            src_cc++;
            case (m)
                1: pkt[1] = 8'h47 ^ 8'($urandom_range(1, 255));
                2: pkt[3] = pkt[3] ^ 8'($urandom_range(1, 255));
                3: src_cc = src_cc + 4'($urandom_range(1, 14));
                4: begin
                    pkt[4] = {2'($urandom), 2'($urandom_range(0, 3)), 4'($urandom)};
                    for (int i = 5; i <= 188; i++) pkt[i] = 8'($urandom);
                end
                5: begin
                    int j;
                    j = $urandom_range(5, 188);
                    pkt[j] = pkt[j] ^ 8'($urandom_range(1, 255));
                end
                default: ;
            endcase
            if (m == 6) begin
                int len;
                len = $urandom_range(1, 187);
                send(len, 1, 0);
                model_pkt(len, 1);
            end else if (m == 7) begin
                send(188, 0, 0);
                model_pkt(188, 0);
            end else begin
                send(188, 1, 0);
                model_pkt(188, 1);
            end
            if (r % 10 == 9) drain($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
